cache_mem_arbiter: RTL

Shares the single 256-bit physical-memory port between the instruction cache and the data cache of the pipelined cache subsystem. It accepts one line-sized transaction at a time and latches the winner's address and write data. It drives physical memory until `pmem_resp`, then returns a registered one-cycle response to the winning cache. When both caches keep requesting, alternating priority prevents either from starving.

---
 rtl/rv32i_types.sv | 9 +
 rtl/cache_arb_fsm.sv | 107 ++++++++++
 rtl/cache_mem_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared cache-subsystem types: memory arbiter state, transaction owner, line offset width.
package rv32i_types;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;

    localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/cache_arb_fsm.sv
// Arbiter control: grant with alternating tie-break, registered pmem strobes and 1-cycle resp pulses.
// Requests are sampled only in IDLE; BUSY waits for pmem_resp with no timeout.
module cache_arb_fsm
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       d_write,
    input  logic       pmem_resp,
    output logic       grant_vld,
    output arb_owner_t grant_owner,
    output logic       grant_write,
    output logic       capture_vld,
    output arb_owner_t owner,
    output logic       pmem_read,
    output logic       pmem_write,
    output logic       i_resp,
    output logic       d_resp
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    arb_owner_t last_served_q, last_served_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       i_resp_q, i_resp_d;
    logic       d_resp_q, d_resp_d;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        i_resp_d      = 1'b0;
        d_resp_d      = 1'b0;
        grant_vld     = 1'b0;
        capture_vld   = 1'b0;

        // On a tie the requester not served last wins.
        if (i_req && d_req) begin
            grant_owner = (last_served_q == OWN_I) ? OWN_D : OWN_I;
        end else begin
            grant_owner = d_req ? OWN_D : OWN_I;
        end
        // A simultaneous dcache read+write resolves to the write.
        grant_write = (grant_owner == OWN_D) && d_write;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_vld = 1'b1;
                    state_d   = BUSY;
                    owner_d   = grant_owner;
                    wr_d      = grant_write;
                    rd_d      = !grant_write;
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    capture_vld   = 1'b1;
                    state_d       = RESP;
                    last_served_d = owner_q;
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    i_resp_d      = (owner_q == OWN_I);
                    d_resp_d      = (owner_q == OWN_D);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            last_served_q <= OWN_I;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            i_resp_q      <= 1'b0;
            d_resp_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            i_resp_q      <= i_resp_d;
            d_resp_q      <= d_resp_d;
        end
    end

    assign owner      = owner_q;
    assign pmem_read  = rd_q;
    assign pmem_write = wr_q;
    assign i_resp     = i_resp_q;
    assign d_resp     = d_resp_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between icache and dcache, one transaction at a time.
// Grant-to-strobe 1 cycle, pmem_resp-to-cache resp 1 cycle; requesters hold until their resp.
module cache_mem_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [ADDR_W-1:0] ADDR_KEEP =
        {{(ADDR_W-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

    logic       grant_vld;
    arb_owner_t grant_owner;
    logic       grant_write;
    logic       capture_vld;
    arb_owner_t owner;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    cache_arb_fsm u_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_read),
        .d_req       (d_read | d_write),
        .d_write     (d_write),
        .pmem_resp   (pmem_resp),
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner),
        .grant_write (grant_write),
        .capture_vld (capture_vld),
        .owner       (owner),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .i_resp      (i_resp),
        .d_resp      (d_resp)
    );

    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (grant_vld) begin
            addr_d  = ((grant_owner == OWN_D) ? d_address : i_address) & ADDR_KEEP;
            wdata_d = grant_write ? d_wdata : '0;
        end
        // Writes return no data; the owner's last read line is kept.
        if (capture_vld && !pmem_write) begin
            if (owner == OWN_I) begin
                i_rdata_d = pmem_rdata;
            end else begin
                d_rdata_d = pmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;

    a_no_dcache_read_and_write:
        assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule
